muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_unit.sv | 170 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Radix-2 shift-add multiplier / restoring divider owning HI/LO.
// Define MULDIV_SIGNED_EN to enable signed MULT/DIV.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   input  logic [1:0]        hilo_wr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   localparam int CW = $clog2(DATA_W + 1);

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] sreg_q, sreg_d;
   logic [DATA_W-1:0] opb_q, opb_d;
   logic              div_q, div_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic              done_q, done_d;
`ifdef MULDIV_SIGNED_EN
   logic              negp_q, negp_d;
   logic              negr_q, negr_d;
`endif

   logic              is_div;
   logic [DATA_W-1:0] a_mag, b_mag;
   logic [DATA_W:0]   mul_sum;
   logic [DATA_W:0]   div_sh;
   logic [DATA_W-1:0] div_rem;
   logic [DATA_W-1:0] step_acc, step_sreg;
   logic [DATA_W-1:0] res_hi, res_lo;

   assign is_div = op_e'(op) inside {OP_DIVU, OP_DIV};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      sreg_d  = sreg_q;
      opb_d   = opb_q;
      div_d   = div_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      a_mag   = rs_data;
      b_mag   = rt_data;
`ifdef MULDIV_SIGNED_EN
      negp_d  = negp_q;
      negr_d  = negr_q;
      if (op[0]) begin
         if (rs_data[DATA_W-1]) a_mag = -rs_data;
         if (rt_data[DATA_W-1]) b_mag = -rt_data;
      end
`endif

      mul_sum = {1'b0, acc_q} + (sreg_q[0] ? {1'b0, opb_q} : '0);
      div_sh  = {acc_q, sreg_q[DATA_W-1]};
      // Remainder stays below the divisor, so DATA_W bits hold it.
      div_rem = div_sh[DATA_W-1:0] - opb_q;

      if (div_q) begin
         if (div_sh >= {1'b0, opb_q}) begin
            step_acc  = div_rem;
            step_sreg = {sreg_q[DATA_W-2:0], 1'b1};
         end else begin
            step_acc  = div_sh[DATA_W-1:0];
            step_sreg = {sreg_q[DATA_W-2:0], 1'b0};
         end
      end else begin
         step_acc  = mul_sum[DATA_W:1];
         step_sreg = {mul_sum[0], sreg_q[DATA_W-1:1]};
      end

      res_hi = step_acc;
      res_lo = step_sreg;
`ifdef MULDIV_SIGNED_EN
      if (div_q) begin
         if (negp_q) res_lo = -step_sreg;
         if (negr_q) res_hi = -step_acc;
      end else if (negp_q) begin
         {res_hi, res_lo} = -{step_acc, step_sreg};
      end
`endif

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_BUSY;
               cnt_d   = '0;
               acc_d   = '0;
               sreg_d  = a_mag;
               opb_d   = b_mag;
               div_d   = is_div;
`ifdef MULDIV_SIGNED_EN
               // Zero divisor keeps the all-ones quotient unsigned.
               negp_d  = op[0] & (rs_data[DATA_W-1] ^ rt_data[DATA_W-1])
                         & (~is_div | (|rt_data));
               negr_d  = op[0] & is_div & rs_data[DATA_W-1];
`endif
            end else begin
               if (hilo_wr[1]) hi_d = wr_data;
               if (hilo_wr[0]) lo_d = wr_data;
            end
         end
         S_BUSY: begin
            acc_d  = step_acc;
            sreg_d = step_sreg;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(DATA_W - 1)) begin
               state_d = S_IDLE;
               hi_d    = res_hi;
               lo_d    = res_lo;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         sreg_q  <= '0;
         opb_q   <= '0;
         div_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
`ifdef MULDIV_SIGNED_EN
         negp_q  <= 1'b0;
         negr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         sreg_q  <= sreg_d;
         opb_q   <= opb_d;
         div_q   <= div_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
`ifdef MULDIV_SIGNED_EN
         negp_q  <= negp_d;
         negr_q  <= negr_d;
`endif
      end
   end

   assign busy = (state_q == S_BUSY);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO queued at launch,
// compared on each done pulse together with latency and handshake.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset, start;
   logic [1:0]    op, hilo_wr;
   logic [DW-1:0] rs_data, rt_data, wr_data;
   logic          busy, done;
   logic [DW-1:0] hi, lo;

   typedef struct {
      logic [DW-1:0] hi;
      logic [DW-1:0] lo;
      int            edge_n;
      string         tag;
   } exp_t;

   exp_t scb[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   logic prev_done = 1'b0;

   muldiv_unit #(.DATA_W(DW)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .hilo_wr (hilo_wr),
      .wr_data (wr_data),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(logic [1:0] o,
                                         logic [DW-1:0] a,
                                         logic [DW-1:0] b);
      logic               sg;
      logic signed [DW-1:0] sa, sbv;
      logic signed [63:0]   xa, xb;
`ifdef MULDIV_SIGNED_EN
      sg = o[0];
`else
      sg = 1'b0;
`endif
      sa  = a;
      sbv = b;
      xa  = sa;
      xb  = sbv;
      if (!o[1]) begin
         if (sg) return xa * xb;
         return {32'h0, a} * {32'h0, b};
      end
      if (b == 0) return {a, 32'hFFFF_FFFF};
      if (sg) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {32'h0, 32'h8000_0000};
         return {32'(sa % sbv), 32'(sa / sbv)};
      end
      return {a % b, a / b};
   endfunction

   always @(negedge clk) begin
      if (done === 1'b1) begin
         chk("done_width", {63'h0, prev_done}, 64'h0);
         chk("busy_with_done", {63'h0, busy}, 64'h0);
         if (scb.size() == 0) begin
            chk("done_unexpected", 64'h1, 64'h0);
         end else begin
            mon_e = scb.pop_front();
            chk({mon_e.tag, "_hi"}, {32'h0, hi}, {32'h0, mon_e.hi});
            chk({mon_e.tag, "_lo"}, {32'h0, lo}, {32'h0, mon_e.lo});
            chk({mon_e.tag, "_lat"}, 64'(cyc - mon_e.edge_n), 64'(DW));
         end
      end
      prev_done = (done === 1'b1);
   end

   task automatic issue(logic [1:0] o, logic [DW-1:0] a, logic [DW-1:0] b,
                        string tag, logic [1:0] hw);
      logic [63:0] r;
      exp_t e;
      @(posedge clk);
      #1;
      start   = 1'b1;
      op      = o;
      rs_data = a;
      rt_data = b;
      hilo_wr = hw;
      @(posedge clk);
      #1;
      start   = 1'b0;
      hilo_wr = 2'b00;
      r = model(o, a, b);
      e.hi = r[63:32];
      e.lo = r[31:0];
      e.edge_n = cyc;
      e.tag = tag;
      scb.push_back(e);
   endtask

   task automatic wait_idle(string tag);
      int k = 0;
      while (scb.size() != 0 && k < 200) begin
         @(posedge clk);
         k++;
      end
      if (scb.size() != 0) begin
         chk({tag, "_timeout"}, 64'h0, 64'h1);
         scb.delete();
      end
   endtask

   task automatic hw_write(logic [1:0] hw, logic [DW-1:0] d);
      @(posedge clk);
      #1;
      hilo_wr = hw;
      wr_data = d;
      @(posedge clk);
      #1;
      hilo_wr = 2'b00;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op = 2'b00;
      hilo_wr = 2'b00;
      rs_data = '0;
      rt_data = '0;
      wr_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {63'h0, busy}, 64'h0);
      chk("rst_done", {63'h0, done}, 64'h0);
      chk("rst_hilo", {hi, lo}, 64'h0);
      @(posedge clk);
      #1 reset = 1'b0;

      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 2'b00);
      wait_idle("multu_max");
      chk("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      issue(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, "mult_neg", 2'b00);
      wait_idle("mult_neg");
      issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg", 2'b00);
      wait_idle("div_neg");
      issue(OP_DIVU, 32'd100, 32'd7, "divu_100_7", 2'b00);
      wait_idle("divu_100_7");
      chk("divu_const", {hi, lo}, {32'd2, 32'd14});
      issue(OP_DIVU, 32'h64, 32'h0, "divu_zero", 2'b00);
      wait_idle("divu_zero");
      chk("divz_const", {hi, lo}, {32'h64, 32'hFFFF_FFFF});
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 2'b00);
      wait_idle("div_ovf");
      issue(OP_DIV, 32'hFFFF_FFF0, 32'h0, "div_zero_s", 2'b00);
      wait_idle("div_zero_s");
      issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, "mult_minmin", 2'b00);
      wait_idle("mult_minmin");

      // Mid-busy start and HI/LO write must both be ignored.
      issue(OP_MULTU, 32'd3, 32'd4, "mul_3x4", 2'b00);
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1;
      op = OP_MULTU;
      rs_data = 32'd7;
      rt_data = 32'd7;
      hilo_wr = 2'b11;
      wr_data = 32'hAAAA_5555;
      @(posedge clk);
      #1;
      start = 1'b0;
      hilo_wr = 2'b00;
      @(negedge clk);
      chk("busy_mid", {63'h0, busy}, 64'h1);
      wait_idle("mul_3x4");
      repeat (40) @(posedge clk);
      chk("mul_3x4_hold", {hi, lo}, {32'h0, 32'd12});
      hw_write(2'b10, 32'hAAAA_5555);
      @(negedge clk);
      chk("mthi", {hi, lo}, {32'hAAAA_5555, 32'd12});
      hw_write(2'b01, 32'h1234_5678);
      @(negedge clk);
      chk("mtlo", {hi, lo}, {32'hAAAA_5555, 32'h1234_5678});
      hw_write(2'b11, 32'h5A5A_A5A5);
      @(negedge clk);
      chk("mthilo", {hi, lo}, {32'h5A5A_A5A5, 32'h5A5A_A5A5});

      // Start beats a same-cycle HI/LO write.
      wr_data = 32'hDEAD_BEEF;
      issue(OP_DIVU, 32'd1000, 32'd9, "start_wins", 2'b11);
      @(negedge clk);
      chk("start_wins_hold", {hi, lo}, {32'h5A5A_A5A5, 32'h5A5A_A5A5});
      wait_idle("start_wins");

      // Reset ten edges into a divide: no result, no done.
      issue(OP_DIVU, 32'd1000, 32'd3, "rst_abort", 2'b00);
      scb.delete();
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("abort_busy", {63'h0, busy}, 64'h0);
      chk("abort_done", {63'h0, done}, 64'h0);
      chk("abort_hilo", {hi, lo}, 64'h0);
      repeat (40) @(posedge clk);
      issue(OP_DIVU, 32'd1000, 32'd3, "post_rst", 2'b00);
      wait_idle("post_rst");

      for (int i = 0; i < 24; i++) begin
         logic [1:0]    ro;
         logic [DW-1:0] ra, rb;
         ro = 2'($urandom_range(0, 3));
         ra = $urandom();
         rb = $urandom();
         if (i % 6 == 1) rb = '0;
         if (i % 6 == 2) rb = rb >> $urandom_range(0, 31);
         if (i % 6 == 3) ra = ra >> $urandom_range(0, 31);
         issue(ro, ra, rb, $sformatf("rnd%0d", i), 2'b00);
         wait_idle("rnd");
      end

      repeat (5) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
